decode_exec_pipe_buf: RTL



---
 rtl/decode_exec_pipe_buf.sv | 86 ++++++++
 1 files changed

// File: rtl/decode_exec_pipe_buf.sv
// decode_exec_pipe_buf: 2-entry elastic buffer between decode and execute, with a flush path and control-field zeroing on bubbles
// Ports: REG_CLOCK/REG_RESET; IN_VALID/IN_READY/IN_DATA/IN_CTRL decode side; FLUSH redirect;
//        OUT_VALID/OUT_READY/OUT_DATA/OUT_CTRL execute side; OCCUPANCY entries held.
// Optional DEC_EX_PERF_EN adds saturating STALL_CNT/BUBBLE_CNT/FLUSH_CNT (CNT_W bits).
module decode_exec_pipe_buf #(
  parameter int XLEN = 32,
  parameter int NUM_WORDS = 7,
  parameter int CTRL_W = 9
`ifdef DEC_EX_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                      REG_CLOCK,
  input  logic                      REG_RESET,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [NUM_WORDS*XLEN-1:0] IN_DATA,
  input  logic [CTRL_W-1:0]         IN_CTRL,
  input  logic                      FLUSH,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [NUM_WORDS*XLEN-1:0] OUT_DATA,
  output logic [CTRL_W-1:0]         OUT_CTRL,
  output logic [1:0]                OCCUPANCY
`ifdef DEC_EX_PERF_EN
  , output logic [CNT_W-1:0]        STALL_CNT,
  output logic [CNT_W-1:0]          BUBBLE_CNT,
  output logic [CNT_W-1:0]          FLUSH_CNT
`endif
);
  localparam int DW = NUM_WORDS*XLEN;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state, state_nx;
  logic [DW-1:0] h_data, s_data;
  logic [CTRL_W-1:0] h_ctrl, s_ctrl;
  logic push, pop;
  assign IN_READY = state != TWO;
  assign OUT_VALID = state != EMPTY;
  assign OCCUPANCY = state;
  assign OUT_DATA = h_data;
  assign OUT_CTRL = OUT_VALID ? h_ctrl : '0;
  assign push = IN_VALID && IN_READY;
  assign pop = OUT_VALID && OUT_READY;
  always_comb begin
    state_nx = state;
    if (FLUSH) state_nx = EMPTY;
    else if (state == EMPTY) state_nx = push ? ONE : EMPTY;
    else if (state == ONE) state_nx = (push && !pop) ? TWO : (!push && pop) ? EMPTY : ONE;
    else state_nx = pop ? ONE : TWO;
  end
  always_ff @(posedge REG_CLOCK) state <= REG_RESET ? EMPTY : state_nx;
  // push can only coincide with pop in ONE, so (EMPTY || pop) selects the head as target
  always_ff @(posedge REG_CLOCK) begin
    if (REG_RESET || FLUSH) begin
      h_data <= '0;
      h_ctrl <= '0;
      s_data <= '0;
      s_ctrl <= '0;
    end else begin
      if (push && (state == EMPTY || pop)) begin
        h_data <= IN_DATA;
        h_ctrl <= IN_CTRL;
      end else if (pop && state == TWO) begin
        h_data <= s_data;
        h_ctrl <= s_ctrl;
      end
      if (push && pop == 1'b0 && state == ONE) begin
        s_data <= IN_DATA;
        s_ctrl <= IN_CTRL;
      end
    end
  end
`ifdef DEC_EX_PERF_EN
  always_ff @(posedge REG_CLOCK) begin
    if (REG_RESET) begin
      STALL_CNT <= '0;
      BUBBLE_CNT <= '0;
      FLUSH_CNT <= '0;
    end else begin
      if (IN_VALID && !IN_READY && STALL_CNT != '1) STALL_CNT <= STALL_CNT + 1'b1;
      if (OUT_READY && !OUT_VALID && BUBBLE_CNT != '1) BUBBLE_CNT <= BUBBLE_CNT + 1'b1;
      if (FLUSH && FLUSH_CNT != '1) FLUSH_CNT <= FLUSH_CNT + 1'b1;
    end
  end
`endif
endmodule
